alu_flag_register: RTL

Sequential flag stage directly downstream of the 8-bit zero detector and the adder/logic byte slice. It captures the per-byte flag signals (zero, carry, sign, overflow) on each valid result byte. It accumulates zero and carry across multi-byte operations (16/24/32-bit ops executed as successive 8-bit passes) and commits the architectural V/N/C/Z flags when the last byte completes. It also supplies the inter-byte carry back to the ALU and supports direct flag loads from the data bus.

---
 rtl/alu_flag_register_if.sv | 47 ++++
 rtl/alu_flag_register.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_register_if.sv
// Bus bundle between the ALU byte slice and the flag register stage.
// Shadow save/restore strobes exist only when ALU_FLAG_SHADOW_EN is defined.
interface alu_flag_register_if;
    logic       res_valid;
    logic       is8bitZero;
    logic       carry_in;
    logic       sign_in;
    logic       ovf_in;
    logic       chain_first;
    logic       chain_last;
    logic [3:0] flag_mask;
    logic       load_en;
    logic [3:0] load_data;
    logic [3:0] flags;
    logic       carry_chain;
    logic       flags_valid;
    logic       busy;
    logic       chain_err;
`ifdef ALU_FLAG_SHADOW_EN
    logic       save_en;
    logic       restore_en;

    modport master (
        output res_valid, is8bitZero, carry_in, sign_in, ovf_in,
               chain_first, chain_last, flag_mask, load_en, load_data,
               save_en, restore_en,
        input  flags, carry_chain, flags_valid, busy, chain_err
    );
    modport slave (
        input  res_valid, is8bitZero, carry_in, sign_in, ovf_in,
               chain_first, chain_last, flag_mask, load_en, load_data,
               save_en, restore_en,
        output flags, carry_chain, flags_valid, busy, chain_err
    );
`else
    modport master (
        output res_valid, is8bitZero, carry_in, sign_in, ovf_in,
               chain_first, chain_last, flag_mask, load_en, load_data,
        input  flags, carry_chain, flags_valid, busy, chain_err
    );
    modport slave (
        input  res_valid, is8bitZero, carry_in, sign_in, ovf_in,
               chain_first, chain_last, flag_mask, load_en, load_data,
        output flags, carry_chain, flags_valid, busy, chain_err
    );
`endif
endinterface

// File: rtl/alu_flag_register.sv
// Flag stage: accumulates Z/C over multi-byte ops and commits {V,N,C,Z}.
// Optional flag shadow register enabled by defining ALU_FLAG_SHADOW_EN.
module alu_flag_register (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_flag_register_if.slave   bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        CHAIN = 1'b1
    } state_t;

    localparam int FLAG_C = 1;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       z_acc_q, z_acc_d;
    logic       c_tmp_q, c_tmp_d;
    logic       flags_valid_q, flags_valid_d;
    logic       chain_err_q, chain_err_d;
    logic       commit_s;
    logic       commit_z_s;
    logic [3:0] commit_flags_s;
`ifdef ALU_FLAG_SHADOW_EN
    logic [3:0] shadow_q, shadow_d;
`endif

    function automatic logic [3:0] mask_merge(input logic [3:0] old_v,
                                              input logic [3:0] new_v,
                                              input logic [3:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.res_valid && bus.chain_first && !bus.chain_last) begin
                    state_d = CHAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            CHAIN: begin
                if (bus.res_valid && bus.chain_last) begin
                    state_d = IDLE;
                end else begin
                    state_d = CHAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-state outputs: commit strobe, protocol error, accumulator updates
    always_comb begin
        commit_s    = 1'b0;
        commit_z_s  = 1'b0;
        chain_err_d = 1'b0;
        z_acc_d     = z_acc_q;
        c_tmp_d     = c_tmp_q;
        case (state_q)
            IDLE: begin
                if (bus.res_valid) begin
                    if (!bus.chain_first) begin
                        chain_err_d = 1'b1;
                    end else if (bus.chain_last) begin
                        commit_s   = 1'b1;
                        commit_z_s = bus.is8bitZero;
                    end else begin
                        z_acc_d = bus.is8bitZero;
                        c_tmp_d = bus.carry_in;
                    end
                end else begin
                    commit_s = 1'b0;
                end
            end
            CHAIN: begin
                if (bus.res_valid) begin
                    if (bus.chain_first) begin
                        // Abort the running chain; the byte restarts accumulation
                        chain_err_d = 1'b1;
                        if (bus.chain_last) begin
                            commit_s   = 1'b1;
                            commit_z_s = bus.is8bitZero;
                            z_acc_d    = 1'b1;
                        end else begin
                            z_acc_d = bus.is8bitZero;
                            c_tmp_d = bus.carry_in;
                        end
                    end else if (bus.chain_last) begin
                        commit_s   = 1'b1;
                        commit_z_s = z_acc_q & bus.is8bitZero;
                        z_acc_d    = 1'b1;
                    end else begin
                        z_acc_d = z_acc_q & bus.is8bitZero;
                        c_tmp_d = bus.carry_in;
                    end
                end else begin
                    commit_s = 1'b0;
                end
            end
            default: begin
                z_acc_d = 1'b1;
            end
        endcase
    end

    // Flag write arbitration: restore > load > commit
    always_comb begin
        commit_flags_s = mask_merge(flags_q,
                                    {bus.ovf_in, bus.sign_in, bus.carry_in, commit_z_s},
                                    bus.flag_mask);
        flags_valid_d  = commit_s;
        flags_d        = flags_q;
`ifdef ALU_FLAG_SHADOW_EN
        shadow_d = bus.save_en ? flags_q : shadow_q;
        if (bus.restore_en) begin
            flags_d = shadow_q;
        end else if (bus.load_en) begin
            flags_d = bus.load_data;
        end else if (commit_s) begin
            flags_d = commit_flags_s;
        end else begin
            flags_d = flags_q;
        end
`else
        if (bus.load_en) begin
            flags_d = bus.load_data;
        end else if (commit_s) begin
            flags_d = commit_flags_s;
        end else begin
            flags_d = flags_q;
        end
`endif
    end

    // Datapath and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q       <= 4'b0000;
            z_acc_q       <= 1'b1;
            c_tmp_q       <= 1'b0;
            flags_valid_q <= 1'b0;
            chain_err_q   <= 1'b0;
        end else begin
            flags_q       <= flags_d;
            z_acc_q       <= z_acc_d;
            c_tmp_q       <= c_tmp_d;
            flags_valid_q <= flags_valid_d;
            chain_err_q   <= chain_err_d;
        end
    end

`ifdef ALU_FLAG_SHADOW_EN
    // Shadow copy of the flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= 4'b0000;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    assign bus.flags       = flags_q;
    assign bus.flags_valid = flags_valid_q;
    assign bus.chain_err   = chain_err_q;
    assign bus.busy        = (state_q == CHAIN);
    assign bus.carry_chain = (state_q == CHAIN) ? c_tmp_q : flags_q[FLAG_C];

endmodule
